matrix_mac_controller: RTL and testbench
========================================

# matrix_mac_controller

Sequencing engine that computes C = A × B for two square `dim`×`dim` unsigned matrices. It sits directly downstream of two `memory` instances (A and B operand stores) and drives a third result store. It issues read strobes and addresses to the operand memories, accumulates the dot products, and writes each C element to the result memory. The whole product is computed once per `start` pulse.

## Interface
- `dim`, 2: matrix dimension; `dim*dim` ≤ 64 (6-bit address space).
- `size`, 8: operand element width (matches operand memory `size`).
- `acc_size`, 17: accumulator and result width, `2*size + clog2(dim)`; the result memory is instantiated with `size = acc_size`.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a multiply; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the final result write.
- `read_a`, `read_b`  out  1  read strobes to operand memories A and B.
- `read_address_a`, `read_address_b`  out  6  operand addresses, row-major (`r*dim + c`).
- `data_a`, `data_b`  in  `size`  operand memory read data.
- `write_c`  out  1  write enable to the result memory.
- `write_address_c`  out  6  result address, `i*dim + j`.
- `write_value_c`  out  `acc_size`  result element.

## Operation
- FSM states are IDLE, FETCH, MAC, WRITE and DONE. Indices i, j and k and the accumulator are registered.
- **IDLE:** when `start`=1, clear i, j, k and acc, then go to FETCH. Otherwise stay in IDLE.
- **FETCH:**
  - Drive `read_a`=`read_b`=1.
  - Drive `read_address_a` = `i*dim+k` and `read_address_b` = `k*dim+j`.
  - Go to MAC.
- **MAC:**
  - Drive `read_a`=`read_b`=0.
  - Compute acc ← acc + `data_a`×`data_b`. The operation is unsigned, the product is `2*size` bits, and it is zero-extended into acc.
  - If k<dim−1: increment k and go to FETCH. Otherwise go to WRITE.
- **WRITE:**
  - Drive `write_c`=1, `write_address_c` = `i*dim+j` and `write_value_c` = acc.
  - Clear acc and k.
  - Advance j, wrapping to 0 with i incremented.
  - If (i,j) was (dim−1, dim−1), go to DONE. Otherwise go to FETCH.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **Read strobe rule:** the operand memories update `data` only on a rising transition of `read`. Therefore every strobe is high for exactly one cycle and low the next. Strobes are never held high across consecutive fetches.
- Address outputs hold their value during MAC so that read data stays valid.
- **`start` while busy:** ignored, with no restart and no queuing.
- **Overflow:** cannot occur at default widths, since the worst case dim·(2^size−1)² < 2^acc_size.

## Timing
- **Reset values:**
  - Outputs `busy`, `done`, `read_a`, `read_b`, `write_c` are 0.
  - All addresses are 0 and `write_value_c` is 0.
  - State is IDLE, and acc, i, j and k are 0.
- **Reset mid-operation:** the block aborts immediately, issues no further writes and does not assert `done`. Result memory elements already written are left unchanged.
- **Cycle sequence:**
  - `start` is sampled high at edge t0.
  - The first FETCH occupies cycle t0+1.
  - Each C element takes 2·dim+1 cycles.
  - For default dim=2, the last WRITE is in cycle t0+20, `done` is high in cycle t0+21, and `busy` falls in cycle t0+22.
  - In general, `done` is high at t0 + dim²·(2·dim+1) + 1.
- **Operand sampling:** operand data is sampled at the end of MAC, one cycle after the strobe rises.
- **Result write:** the result memory captures the write on the edge that ends WRITE.
- **Back-to-back runs:** a new `start` is accepted in the first IDLE cycle after DONE.

## Test plan
- **Reset-loaded operands:** A and B are both reset to [[0,85],[1,170]], then `start` is pulsed. Required: C = [[85,14450],[170,28985]] at addresses 0..3, and `done` in cycle t0+21.
- **Identity:** A = [[1,0],[0,1]] and B = [[7,9],[3,255]]. Required: C = B exactly, with exactly 4 `write_c` pulses in the order 0,1,2,3.
- **Max values:** A and B all 255. Required: every C element = 130050 with no truncation.
- **Strobe protocol and busy start:**
  - Check that `read_a` and `read_b` are never high on two consecutive cycles, and that addresses are stable across each FETCH/MAC pair.
  - Pulse `start` at cycle t0+5. Required: sequence and result are unchanged, and only one `done` is produced.
- **Mid-run reset:**
  - Assert `rst` asynchronously in the middle of the computation, at t0+8. Required: outputs go to 0 immediately, no `done`, and writes after the first element stop.
  - Then release `rst` and pulse `start` again. Required: the full correct result.

Source files
------------

// File: rtl/matrix_mac_if.sv
// Handshake and memory-bus bundle between the matrix MAC sequencer and its
// operand/result memories. The master modport is the sequencer's view.
interface matrix_mac_if #(
    parameter int SIZE     = 8,
    parameter int ACC_SIZE = 17,
    parameter int ADDR_W   = 6
);
    logic                start;
    logic                busy;
    logic                done;
    logic                read_a;
    logic                read_b;
    logic [ADDR_W-1:0]   read_address_a;
    logic [ADDR_W-1:0]   read_address_b;
    logic [SIZE-1:0]     data_a;
    logic [SIZE-1:0]     data_b;
    logic                write_c;
    logic [ADDR_W-1:0]   write_address_c;
    logic [ACC_SIZE-1:0] write_value_c;

    modport master (
        input  start, data_a, data_b,
        output busy, done, read_a, read_b, read_address_a, read_address_b,
               write_c, write_address_c, write_value_c
    );

    modport slave (
        output start, data_a, data_b,
        input  busy, done, read_a, read_b, read_address_a, read_address_b,
               write_c, write_address_c, write_value_c
    );
endinterface

// File: rtl/matrix_mac_controller.sv
// Computes C = A x B for square DIM x DIM unsigned matrices held in external
// operand memories, one start pulse per full product. Each C element is a
// sequence of FETCH/MAC pairs (one per k) followed by a single WRITE.
module matrix_mac_controller #(
    parameter int DIM      = 2,
    parameter int SIZE     = 8,
    parameter int ACC_SIZE = 17,
    parameter int ADDR_W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    matrix_mac_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, MAC, WRITE, DONE} state_t;

    localparam logic [ADDR_W-1:0] DIM_A = ADDR_W'(DIM);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DIM - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   i_reg, i_next;
    logic [ADDR_W-1:0]   j_reg, j_next;
    logic [ADDR_W-1:0]   k_reg, k_next;
    logic [ACC_SIZE-1:0] acc_reg, acc_next;

    logic [2*SIZE-1:0]   product;
    logic [ADDR_W-1:0]   addr_a;
    logic [ADDR_W-1:0]   addr_b;
    logic [ADDR_W-1:0]   addr_c;

    // Full-width unsigned product; operands are zero-extended first so the
    // multiply is evaluated at 2*SIZE bits.
    assign product = {{SIZE{1'b0}}, bus.data_a} * {{SIZE{1'b0}}, bus.data_b};
    assign addr_a  = i_reg * DIM_A + k_reg;
    assign addr_b  = k_reg * DIM_A + j_reg;
    assign addr_c  = i_reg * DIM_A + j_reg;

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            k_reg     <= k_next;
            acc_reg   <= acc_next;
        end
    end

    // Next-state, index/accumulator update and decoded outputs. Outputs are
    // decoded from the state so a reset forces them to zero immediately.
    always_comb begin
        state_next          = state_reg;
        i_next              = i_reg;
        j_next              = j_reg;
        k_next              = k_reg;
        acc_next            = acc_reg;
        bus.busy            = (state_reg != IDLE);
        bus.done            = 1'b0;
        bus.read_a          = 1'b0;
        bus.read_b          = 1'b0;
        bus.read_address_a  = '0;
        bus.read_address_b  = '0;
        bus.write_c         = 1'b0;
        bus.write_address_c = '0;
        bus.write_value_c   = '0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    i_next     = '0;
                    j_next     = '0;
                    k_next     = '0;
                    acc_next   = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // One-cycle strobe: the memories load data on its rising edge.
                bus.read_a         = 1'b1;
                bus.read_b         = 1'b1;
                bus.read_address_a = addr_a;
                bus.read_address_b = addr_b;
                state_next         = MAC;
            end
            MAC: begin
                // Addresses stay put so the read data remains valid here.
                bus.read_address_a = addr_a;
                bus.read_address_b = addr_b;
                acc_next           = acc_reg + ACC_SIZE'(product);
                if (k_reg < LAST) begin
                    k_next     = k_reg + 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                bus.write_c         = 1'b1;
                bus.write_address_c = addr_c;
                bus.write_value_c   = acc_reg;
                acc_next            = '0;
                k_next              = '0;
                if (j_reg == LAST) begin
                    j_next = '0;
                    i_next = i_reg + 1'b1;
                    state_next = (i_reg == LAST) ? DONE : FETCH;
                end else begin
                    j_next     = j_reg + 1'b1;
                    state_next = FETCH;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_matrix_mac_controller.sv
// Self-checking bench for matrix_mac_controller: behavioural operand memories,
// a scoreboard of expected result writes, a table of 2x2 products and
// hand-written sequences for busy-start and mid-run reset.
module tb_matrix_mac_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    matrix_mac_if #(.SIZE(8), .ACC_SIZE(17), .ADDR_W(6)) bus ();

    matrix_mac_controller #(.DIM(2), .SIZE(8), .ACC_SIZE(17), .ADDR_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][16:0] c;
        logic [7:0]       busy_start;
    } vec_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [16:0] val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  mem_a[4];
    logic [7:0]  mem_b[4];
    logic        ra_prev = 1'b0;
    logic        rb_prev = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int n_done   = 0;

    logic       mon_prev_ra = 1'b0;
    logic [5:0] mon_prev_addr_a = '0;
    logic [5:0] mon_prev_addr_b = '0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Operand memories: data updates only on a rising read strobe.
    always @(posedge clk) begin
        if (bus.read_a && !ra_prev) bus.data_a <= mem_a[bus.read_address_a[1:0]];
        if (bus.read_b && !rb_prev) bus.data_b <= mem_b[bus.read_address_b[1:0]];
        ra_prev <= bus.read_a;
        rb_prev <= bus.read_b;
    end

    // Output monitor: scoreboard writes, count done pulses, check strobes.
    always @(negedge clk) begin
        if (rst) begin
            mon_prev_ra = 1'b0;
        end else begin
            if (bus.write_c) begin
                n_writes++;
                $display("write addr=%0d value=%0d", bus.write_address_c, bus.write_value_c);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", bus.write_address_c, mon_e.addr);
                    check("write_value", bus.write_value_c, mon_e.val);
                end
            end
            if (bus.done) n_done++;
            if (mon_prev_ra) begin
                check("read_a_single", bus.read_a, 0);
                check("read_b_single", bus.read_b, 0);
                check("addr_a_hold", bus.read_address_a, mon_prev_addr_a);
                check("addr_b_hold", bus.read_address_b, mon_prev_addr_b);
            end
            mon_prev_ra     = bus.read_a;
            mon_prev_addr_a = bus.read_address_a;
            mon_prev_addr_b = bus.read_address_b;
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_read_a"}, bus.read_a, 0);
        check({tag, "_read_b"}, bus.read_b, 0);
        check({tag, "_write_c"}, bus.write_c, 0);
        check({tag, "_addr_a"}, bus.read_address_a, 0);
        check({tag, "_addr_b"}, bus.read_address_b, 0);
        check({tag, "_addr_c"}, bus.write_address_c, 0);
        check({tag, "_value_c"}, bus.write_value_c, 0);
    endtask

    // One full multiply: called at a negedge, returns at the first IDLE
    // negedge after DONE so the next call exercises a back-to-back start.
    task automatic run_case(input vec_t v, input string tag);
        int lat;
        int w0;
        int d0;
        bit got;
        for (int n = 0; n < 4; n++) begin
            mem_a[n] = v.a[n];
            mem_b[n] = v.b[n];
            exp_q.push_back({6'(n), v.c[n]});
        end
        w0 = n_writes;
        d0 = n_done;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            bus.start = (lat == int'(v.busy_start));
            if (bus.done) got = 1'b1;
        end
        bus.start = 1'b0;
        if (!got) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            check({tag, "_done_cycle"}, lat, 21);
        end
        @(negedge clk);
        check({tag, "_busy_after"}, bus.busy, 0);
        check({tag, "_write_count"}, n_writes - w0, 4);
        check({tag, "_done_count"}, n_done - d0, 1);
        check({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        $display("run %s: done after %0d cycles, %0d writes", tag, lat, n_writes - w0);
    endtask

    function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3,
                                input int c0, c1, c2, c3, input int bs);
        vec_t v;
        v.a = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
        v.b = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
        v.c = {17'(c3), 17'(c2), 17'(c1), 17'(c0)};
        v.busy_start = 8'(bs);
        return v;
    endfunction

    vec_t vecs[4];
    vec_t rv;
    int   w_mid;
    int   d_mid;
    int   lat_mid;

    initial begin
        bus.start  = 1'b0;
        bus.data_a = '0;
        bus.data_b = '0;
        for (int n = 0; n < 4; n++) begin
            mem_a[n] = '0;
            mem_b[n] = '0;
        end

        vecs[0] = mk(0, 85, 1, 170,  0, 85, 1, 170,  85, 14450, 170, 28985, 0);
        vecs[1] = mk(1, 0, 0, 1,  7, 9, 3, 255,  7, 9, 3, 255, 0);
        vecs[2] = mk(255, 255, 255, 255,  255, 255, 255, 255,
                     130050, 130050, 130050, 130050, 0);
        vecs[3] = mk(2, 3, 4, 5,  6, 7, 8, 9,  36, 41, 64, 73, 5);

        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle");

        for (int t = 0; t < 4; t++) begin
            run_case(vecs[t], $sformatf("vec%0d", t));
        end

        // Random operands, expected product from a reference model.
        rv = '0;
        for (int n = 0; n < 4; n++) begin
            rv.a[n] = 8'($urandom_range(0, 255));
            rv.b[n] = 8'($urandom_range(0, 255));
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                rv.c[r*2+c] = 17'(int'(rv.a[r*2]) * int'(rv.b[c]) +
                                  int'(rv.a[r*2+1]) * int'(rv.b[2+c]));
            end
        end
        run_case(rv, "random");

        // Mid-run reset: only element 0 may be written, no done.
        for (int n = 0; n < 4; n++) begin
            mem_a[n] = vecs[3].a[n];
            mem_b[n] = vecs[3].b[n];
        end
        exp_q.push_back({6'd0, vecs[3].c[0]});
        w_mid = n_writes;
        d_mid = n_done;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat_mid = 0;
        while (lat_mid < 8) begin
            @(negedge clk);
            lat_mid++;
        end
        check("mid_busy_before", bus.busy, 1);
        #2 rst = 1'b1;
        #1 check_quiet("midrst");
        repeat (3) @(negedge clk);
        check_quiet("midrst_hold");
        #2 rst = 1'b0;
        @(negedge clk);
        check("midrst_write_count", n_writes - w_mid, 1);
        check("midrst_done_count", n_done - d_mid, 0);
        check("midrst_pending", exp_q.size(), 0);
        exp_q.delete();
        $display("run midrst: aborted at cycle %0d, %0d writes", lat_mid, n_writes - w_mid);

        run_case(vecs[3], "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
